// File: rtl/wb_group_arbiter.sv
// -----------------------------------------------------------------------------
// wb_group_arbiter
//
// Round-robin arbiter that lets NUM_UNITS writeback units share a single
// register-bank commit port. Each cycle at most one pending unit is acked.
// Its destination address, data and instruction id are registered onto the
// commit port one cycle later. Writes to physical register 0 are acked but
// never committed.
//
// Ports
//   clk, rst_n          : clock, asynchronous active-low reset
//   unit_valid[k]       : unit k has a result pending
//   unit_phys_addr      : packed per-unit destination register (slice k)
//   unit_data           : packed per-unit result data (slice k)
//   unit_id             : packed per-unit instruction id (slice k)
//   unit_ack[k]         : combinational one-hot-or-zero accept strobe
//   writeback_supress   : global stall; no results accepted while high
//   commit_valid        : registered commit packet valid
//   commit_phys_addr    : registered commit destination register
//   commit_data         : registered commit data
//   commit_id           : registered commit instruction id
// -----------------------------------------------------------------------------
module wb_group_arbiter #(
  parameter int NUM_UNITS   = 4,  // legal range 2..8
  parameter int DATA_WIDTH  = 32,
  parameter int PHYS_ADDR_W = 6,
  parameter int ID_W        = 3
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_UNITS-1:0]              unit_valid,
  input  logic [NUM_UNITS*PHYS_ADDR_W-1:0]  unit_phys_addr,
  input  logic [NUM_UNITS*DATA_WIDTH-1:0]   unit_data,
  input  logic [NUM_UNITS*ID_W-1:0]         unit_id,
  output logic [NUM_UNITS-1:0]              unit_ack,
  input  logic                              writeback_supress,
  output logic                              commit_valid,
  output logic [PHYS_ADDR_W-1:0]            commit_phys_addr,
  output logic [DATA_WIDTH-1:0]             commit_data,
  output logic [ID_W-1:0]                   commit_id
);

  localparam int PTR_W = $clog2(NUM_UNITS);

  logic [PTR_W-1:0]       r_ptr;
  logic [PTR_W-1:0]       w_ptr_next;
  logic [NUM_UNITS-1:0]   w_req_hi;   // valid units at or above the pointer
  logic [NUM_UNITS-1:0]   w_req;      // request set the winner is picked from
  logic [NUM_UNITS-1:0]   w_pick;     // lowest set bit of w_req
  logic                   w_grant;
  logic [PHYS_ADDR_W-1:0] w_sel_addr;
  logic [DATA_WIDTH-1:0]  w_sel_data;
  logic [ID_W-1:0]        w_sel_id;
  logic                   w_commit;

  // Grant search. Searching upward from r_ptr with wrap-around is the same as
  // taking the lowest valid unit at or above r_ptr. If there is none, take the
  // lowest valid unit overall. This avoids a modulo on a variable index.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    w_req_hi   = '0;
    w_pick     = '0;
    unit_ack   = '0;
    w_grant    = 1'b0;
    w_ptr_next = r_ptr;
    w_sel_addr = '0;
    w_sel_data = '0;
    w_sel_id   = '0;

    for (int k = 0; k < NUM_UNITS; k++) begin
      w_req_hi[k] = unit_valid[k] && (k >= int'(r_ptr));
    end
    w_req = (|w_req_hi) ? w_req_hi : unit_valid;

    for (int k = 0; k < NUM_UNITS; k++) begin
      if (w_req[k] && (w_pick == '0)) begin
        w_pick[k] = 1'b1;
      end
    end

    // Reset and stall both mask the grant, so neither the ack nor the pointer
    // can move while either one is active.
    if (rst_n && !writeback_supress && (w_pick != '0)) begin
      w_grant  = 1'b1;
      unit_ack = w_pick;
      for (int k = 0; k < NUM_UNITS; k++) begin
        if (w_pick[k]) begin
          w_sel_addr = unit_phys_addr[k*PHYS_ADDR_W +: PHYS_ADDR_W];
          w_sel_data = unit_data[k*DATA_WIDTH +: DATA_WIDTH];
          w_sel_id   = unit_id[k*ID_W +: ID_W];
          w_ptr_next = (k == NUM_UNITS-1) ? '0 : PTR_W'(k + 1);
        end
      end
    end
  end

  // A transfer to register 0 still consumes the grant but carries nothing.
  assign w_commit = w_grant && (w_sel_addr != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr            <= '0;
      commit_valid     <= 1'b0;
      commit_phys_addr <= '0;
      commit_data      <= '0;
      commit_id        <= '0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      commit_valid <= w_commit;
      if (w_grant) begin
        r_ptr <= w_ptr_next;
      end
      // The payload holds its last committed value when nothing is committed.
      if (w_commit) begin
        commit_phys_addr <= w_sel_addr;
        commit_data      <= w_sel_data;
        commit_id        <= w_sel_id;
      end
    end
  end

endmodule

// File: tb/tb_wb_group_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_group_arbiter
//
// Directed bench for wb_group_arbiter with the default parameters (4 units,
// 32-bit data, 6-bit address, 3-bit id). Inputs change just after the falling
// edge. unit_ack is sampled 1 ns later, and the registered commit port is
// sampled at the next falling edge. A randomised traffic phase then checks the
// following:
//   - ack is one-hot or zero,
//   - ack is a subset of valid,
//   - the wait before an ack is bounded,
//   - every ack maps one-to-one onto a commit.
// -----------------------------------------------------------------------------
module tb_wb_group_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   unit_valid;
  logic [23:0]  unit_phys_addr;
  logic [127:0] unit_data;
  logic [11:0]  unit_id;
  logic [3:0]   unit_ack;
  logic         writeback_supress;
  logic         commit_valid;
  logic [5:0]   commit_phys_addr;
  logic [31:0]  commit_data;
  logic [2:0]   commit_id;

  int total = 0;
  int bad   = 0;

  wb_group_arbiter #(
    .NUM_UNITS  (4),
    .DATA_WIDTH (32),
    .PHYS_ADDR_W(6),
    .ID_W       (3)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .unit_valid       (unit_valid),
    .unit_phys_addr   (unit_phys_addr),
    .unit_data        (unit_data),
    .unit_id          (unit_id),
    .unit_ack         (unit_ack),
    .writeback_supress(writeback_supress),
    .commit_valid     (commit_valid),
    .commit_phys_addr (commit_phys_addr),
    .commit_data      (commit_data),
    .commit_id        (commit_id)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_unit(input int k, input logic v, input logic [5:0] a,
                          input logic [31:0] d, input logic [2:0] id);
    unit_valid[k]             = v;
    unit_phys_addr[k*6 +: 6]  = a;
    unit_data[k*32 +: 32]     = d;
    unit_id[k*3 +: 3]         = id;
  endtask

  // Check the combinational ack, then advance across one rising edge.
  task automatic ack_then_edge(input string tag, input logic [3:0] exp);
    #1 check({tag, " ack"}, 64'(unit_ack), 64'(exp));
    @(negedge clk);
  endtask

  task automatic commit_chk(input string tag, input logic v, input logic [5:0] a,
                            input logic [31:0] d, input logic [2:0] id);
    check({tag, " commit_valid"}, 64'(commit_valid), 64'(v));
    if (v) begin
      check({tag, " commit_addr"}, 64'(commit_phys_addr), 64'(a));
      check({tag, " commit_data"}, 64'(commit_data), 64'(d));
      check({tag, " commit_id"},   64'(commit_id),   64'(id));
    end
  endtask

  initial begin
    logic       exp_cv;
    logic [5:0] ea;
    logic [31:0] ed;
    logic [2:0] eid;
    logic [3:0] ack_s;
    int         waitc [4];
    int         maxw;

    rst_n             = 1'b0;
    writeback_supress = 1'b0;
    unit_valid        = '0;
    unit_phys_addr    = '0;
    unit_data         = '0;
    unit_id           = '0;
    for (int k = 0; k < 4; k++) set_unit(k, 1'b1, 6'(k + 1), 32'(32'h1000 + k), 3'(k));

    // Reset state: with every unit valid, the ack must still be zero.
    #2;
    check("reset ack", 64'(unit_ack), 64'(0));
    check("reset commit_valid", 64'(commit_valid), 64'(0));
    check("reset commit_addr", 64'(commit_phys_addr), 64'(0));
    check("reset commit_data", 64'(commit_data), 64'(0));
    check("reset commit_id", 64'(commit_id), 64'(0));

    @(negedge clk);
    rst_n = 1'b1;

    // All four units valid: grants go 0,1,2,3 and each commits one cycle later.
    for (int i = 0; i < 4; i++) begin
      ack_then_edge("rr", 4'(1 << i));
      commit_chk("rr", 1'b1, 6'(i + 1), 32'(32'h1000 + i), 3'(i));
    end

    // No transfer: commit_valid drops and the payload holds.
    unit_valid = '0;
    ack_then_edge("idle", 4'b0000);
    check("idle commit_valid", 64'(commit_valid), 64'(0));
    check("idle hold data", 64'(commit_data), 64'(32'h1003));

    // Unit 2 alone (ptr=0), then back-to-back (ptr=3).
    set_unit(2, 1'b1, 6'd5, 32'hDEADBEEF, 3'd3);
    ack_then_edge("single", 4'b0100);
    commit_chk("single", 1'b1, 6'd5, 32'hDEADBEEF, 3'd3);
    ack_then_edge("b2b", 4'b0100);
    commit_chk("b2b", 1'b1, 6'd5, 32'hDEADBEEF, 3'd3);
    unit_valid[2] = 1'b0;

    // Unit 1 writes x0: it is acked but dropped, and ptr advances to 2.
    set_unit(1, 1'b1, 6'd0, 32'h55, 3'd1);
    ack_then_edge("x0", 4'b0010);
    check("x0 commit_valid", 64'(commit_valid), 64'(0));
    unit_valid[1] = 1'b0;

    // Three-cycle stall with units 1 and 3 valid and ptr=2.
    set_unit(1, 1'b1, 6'd9,  32'hA1, 3'd1);
    set_unit(3, 1'b1, 6'd10, 32'hA3, 3'd5);
    writeback_supress = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ack_then_edge("stall", 4'b0000);
      check("stall commit_valid", 64'(commit_valid), 64'(0));
    end
    writeback_supress = 1'b0;
    ack_then_edge("release first", 4'b1000);
    commit_chk("release first", 1'b1, 6'd10, 32'hA3, 3'd5);
    unit_valid[3] = 1'b0;
    ack_then_edge("release second", 4'b0010);
    commit_chk("release second", 1'b1, 6'd9, 32'hA1, 3'd1);
    unit_valid[1] = 1'b0;

    // Commit from unit 0 (ptr=2 -> search 2,3,0), leaving ptr=1.
    set_unit(0, 1'b1, 6'd7, 32'hC0, 3'd2);
    ack_then_edge("pre-reset", 4'b0001);
    commit_chk("pre-reset", 1'b1, 6'd7, 32'hC0, 3'd2);

    // Asynchronous reset between edges discards the packet and clears ptr.
    set_unit(0, 1'b1, 6'd11, 32'hB0, 3'd4);
    set_unit(3, 1'b1, 6'd12, 32'hB3, 3'd6);
    #1 rst_n = 1'b0;
    #1;
    check("async reset commit_valid", 64'(commit_valid), 64'(0));
    check("async reset ack", 64'(unit_ack), 64'(0));
    check("async reset commit_data", 64'(commit_data), 64'(0));
    #1 rst_n = 1'b1;
    ack_then_edge("post-reset first", 4'b0001);
    commit_chk("post-reset first", 1'b1, 6'd11, 32'hB0, 3'd4);
    unit_valid[0] = 1'b0;
    ack_then_edge("post-reset second", 4'b1000);
    commit_chk("post-reset second", 1'b1, 6'd12, 32'hB3, 3'd6);
    unit_valid = '0;

    // Random traffic. Each unit holds its payload until acked, then may issue anew.
    exp_cv = 1'b0;
    ea = '0; ed = '0; eid = '0;
    for (int k = 0; k < 4; k++) waitc[k] = 0;
    for (int c = 0; c < 2000; c++) begin
      if (c > 0) commit_chk("rnd", exp_cv, ea, ed, eid);
      for (int k = 0; k < 4; k++) begin
        if (!unit_valid[k] && ($urandom_range(0, 2) == 0)) begin
          set_unit(k, 1'b1,
                   ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom_range(1, 63)),
                   $urandom, 3'($urandom_range(0, 7)));
        end
      end
      writeback_supress = ($urandom_range(0, 7) == 0);
      #1;
      ack_s = unit_ack;
      check("rnd ack legal",
            64'($onehot0(ack_s) && ((ack_s & ~unit_valid) == 4'b0000) &&
                !(writeback_supress && (ack_s != 4'b0000))),
            64'(1));
      exp_cv = 1'b0;
      maxw   = 0;
      for (int k = 0; k < 4; k++) begin
        if (ack_s[k]) begin
          exp_cv   = (unit_phys_addr[k*6 +: 6] != 6'd0);
          ea       = unit_phys_addr[k*6 +: 6];
          ed       = unit_data[k*32 +: 32];
          eid      = unit_id[k*3 +: 3];
          waitc[k] = 0;
        end else if (unit_valid[k] && !writeback_supress) begin
          waitc[k]++;
        end
        if (waitc[k] > maxw) maxw = waitc[k];
      end
      check("rnd starvation", 64'(maxw <= 3), 64'(1));
      @(negedge clk);
      for (int k = 0; k < 4; k++) if (ack_s[k]) unit_valid[k] = 1'b0;
    end
    commit_chk("rnd last", exp_cv, ea, ed, eid);
    writeback_supress = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
